// File: rtl/conv_sequencer.sv
// conv_sequencer: steps one full linear convolution y[n] = sum_k h[k]*x[n-k].
// Drives the coefficient ROM address (k), the data memory address (n-k) and
// the external MAC controls, and flags each finished y[n].
// Optional feature macro: CONV_BACKPRESSURE_EN adds out_ready and makes EMIT
// wait for out_valid & out_ready before advancing.
module conv_sequencer #(
  parameter int ADD   = 6,
  parameter int MAX_X = 50,
  parameter int MAX_H = 32,
  parameter int YW    = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ADD-1:0] len_x,
  input  logic [ADD-1:0] len_h,
  output logic [ADD-1:0] rom_addr,
  output logic [ADD-1:0] x_addr,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           out_valid,
  output logic [YW-1:0]  out_idx,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
`ifdef CONV_BACKPRESSURE_EN
  ,
  input  logic           out_ready
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADD-1:0] LP_MAX_X = ADD'(MAX_X);
  localparam logic [ADD-1:0] LP_MAX_H = ADD'(MAX_H);

  logic [2:0]     r_state;
  logic [ADD-1:0] r_len_x;
  logic [ADD-1:0] r_len_h;
  logic [ADD-1:0] r_rom_addr;
  logic [ADD-1:0] r_x_addr;
  logic [YW-1:0]  r_n;
  logic           r_cfg_err;

  logic [YW-1:0]  w_n_plus1;
  logic [YW-1:0]  w_lx;
  logic [YW-1:0]  w_lh_m1;
  logic [YW-1:0]  w_last_n;
  logic [YW-1:0]  w_kmax;
  logic           w_kmin_pos;
  logic [ADD-1:0] w_kmin;
  logic [ADD-1:0] w_xstart;
  logic           w_acc_last;
  logic           w_emit_go;
  logic           w_len_zero;
  logic           w_len_over;

  // Tap range for the current n, evaluated at YW width so nothing wraps;
  // kmin and n-kmin always fit ADD bits, so their low bits are exact.
  assign w_n_plus1  = r_n + YW'(1);
  assign w_lx       = YW'(r_len_x);
  assign w_lh_m1    = YW'(r_len_h) - YW'(1);
  assign w_last_n   = YW'(r_len_x) + YW'(r_len_h) - YW'(2);
  assign w_kmax     = (r_n < w_lh_m1) ? r_n : w_lh_m1;
  assign w_kmin_pos = (w_n_plus1 > w_lx);
  assign w_kmin     = w_kmin_pos ? (w_n_plus1[ADD-1:0] - r_len_x) : '0;
  assign w_xstart   = r_n[ADD-1:0] - w_kmin;
  assign w_acc_last = (YW'(r_rom_addr) == w_kmax);
  assign w_len_zero = (len_x == '0) || (len_h == '0);
  assign w_len_over = (len_x > LP_MAX_X) || (len_h > LP_MAX_H);

`ifdef CONV_BACKPRESSURE_EN
  assign w_emit_go = out_ready;
`else
  assign w_emit_go = 1'b1;
`endif

  // Sequencer state, captured lengths, n counter and the address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len_x    <= '0;
      r_len_h    <= '0;
      r_rom_addr <= '0;
      r_x_addr   <= '0;
      r_n        <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_x   <= len_x;
            r_len_h   <= len_h;
            r_n       <= '0;
            r_cfg_err <= 1'b0;
            if (w_len_zero) begin
              r_state <= S_DONE;
            end else if (w_len_over) begin
              r_state   <= S_DONE;
              r_cfg_err <= 1'b1;
            end else begin
              r_state <= S_CLR;
            end
          end
        end
        S_CLR: begin
          r_rom_addr <= w_kmin;
          r_x_addr   <= w_xstart;
          r_state    <= S_ACC;
        end
        S_ACC: begin
          if (w_acc_last) begin
            r_state <= S_EMIT;
          end else begin
            r_rom_addr <= r_rom_addr + ADD'(1);
            r_x_addr   <= r_x_addr - ADD'(1);
          end
        end
        S_EMIT: begin
          if (w_emit_go) begin
            if (r_n == w_last_n) begin
              r_state <= S_DONE;
            end else begin
              r_n     <= w_n_plus1;
              r_state <= S_CLR;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = r_rom_addr;
  assign x_addr    = r_x_addr;
  assign mac_clr   = (r_state == S_CLR);
  assign mac_en    = (r_state == S_ACC);
  assign out_valid = (r_state == S_EMIT);
  assign out_idx   = r_n;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: expands each run into its expected per-cycle output
// trace from the tap-range rules, checks the DUT every cycle against it, and
// checks the accumulated MAC result against a direct convolution sum.
module tb_conv_sequencer;
  localparam int ADD   = 6;
  localparam int MAX_X = 50;
  localparam int MAX_H = 32;
  localparam int YW    = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [ADD-1:0] len_x;
  logic [ADD-1:0] len_h;
  logic [ADD-1:0] rom_addr;
  logic [ADD-1:0] x_addr;
  logic           mac_clr;
  logic           mac_en;
  logic           out_valid;
  logic [YW-1:0]  out_idx;
  logic           busy;
  logic           done;
  logic           cfg_err;
`ifdef CONV_BACKPRESSURE_EN
  logic           out_ready;
`endif

  always #5 clk = ~clk;

  conv_sequencer #(.ADD(ADD), .MAX_X(MAX_X), .MAX_H(MAX_H), .YW(YW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len_x     (len_x),
    .len_h     (len_h),
    .rom_addr  (rom_addr),
    .x_addr    (x_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
`ifdef CONV_BACKPRESSURE_EN
    ,
    .out_ready (out_ready)
`endif
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cfg;
    logic       clr;
    logic       en;
    logic       ov;
    logic [5:0] rom;
    logic [5:0] xa;
    logic [6:0] idx;
  } exp_t;

  exp_t       q[$];
  logic       m_cfg;
  logic [5:0] m_rom;
  logic [5:0] m_x;
  longint     h_mem [64];
  longint     x_mem [64];
  longint     yexp  [128];
  longint     acc;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         cyc0;
  int         ov_cnt;
  int         done_cnt;
  int         done_cyc;
  bit         chk_en = 1'b0;

  function automatic exp_t mk(input logic b, input logic d, input logic c,
                              input logic e, input logic o, input int n);
    exp_t r;
    r.busy = b; r.done = d; r.cfg = m_cfg; r.clr = c; r.en = e; r.ov = o;
    r.rom = m_rom; r.xa = m_x; r.idx = 7'(n);
    return r;
  endfunction

  // Expected trace: entry 0 is the cycle before the start edge, entry j the
  // cycle after edge j-1.
  function automatic void build(input int lx, input int lh);
    int ly, kmin, kmax;
    longint s;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    if (lx == 0 || lh == 0) begin
      m_cfg = 1'b0;
      q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end else if (lx > MAX_X || lh > MAX_H) begin
      m_cfg = 1'b1;
      q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end else begin
      m_cfg = 1'b0;
      ly = lx + lh - 1;
      for (int n = 0; n < ly; n++) begin
        s = 0;
        for (int k = 0; k < lh; k++)
          if (n - k >= 0 && n - k < lx) s += h_mem[k] * x_mem[n-k];
        yexp[n] = s;
        q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        kmin = (n - lx + 1 > 0) ? n - lx + 1 : 0;
        kmax = (n < lh - 1) ? n : lh - 1;
        for (int k = kmin; k <= kmax; k++) begin
          m_rom = 6'(k);
          m_x   = 6'(n - k);
          q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
        end
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, n));
      end
      q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end
  endfunction

  // External accumulator driven by the DUT's MAC controls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= 0;
    else if (mac_clr) acc <= 0;
    else if (mac_en)  acc <= acc + h_mem[rom_addr] * x_mem[x_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of every output against the expected trace.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      tests++;
      if ({busy, done, cfg_err, mac_clr, mac_en, out_valid, rom_addr, x_addr} !==
          {e.busy, e.done, e.cfg, e.clr, e.en, e.ov, e.rom, e.xa} ||
          (e.ov && out_idx !== e.idx)) begin
        fails++;
        $display("FAIL trace cyc=%0d act busy%0b done%0b cfg%0b clr%0b en%0b ov%0b rom%0d x%0d idx%0d req busy%0b done%0b cfg%0b clr%0b en%0b ov%0b rom%0d x%0d idx%0d",
                 cyc, busy, done, cfg_err, mac_clr, mac_en, out_valid, rom_addr, x_addr, out_idx,
                 e.busy, e.done, e.cfg, e.clr, e.en, e.ov, e.rom, e.xa, e.idx);
      end
      if (out_valid) begin
        tests++;
        if (acc !== yexp[out_idx]) begin
          fails++;
          $display("FAIL y[%0d] act %0d req %0d", out_idx, acc, yexp[out_idx]);
        end
        ov_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s act %0d req %0d", nm, act, req);
    end
  endtask

  task automatic fill_mems();
    for (int i = 0; i < 64; i++) begin
      h_mem[i] = longint'($urandom_range(0, 65535));
      x_mem[i] = longint'($urandom_range(0, 65535));
    end
  endtask

  // Called at posedge+1: drives the start pulse and builds the trace.
  task automatic launch(input int lx, input int lh);
    len_x = 6'(lx);
    len_h = 6'(lh);
    start = 1'b1;
    ov_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    build(lx, lh);
  endtask

  task automatic release_start();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (q.size() > 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (q.size() > 0) begin
      chk("timeout_remaining_entries", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int lx, lh, sel, e4, seen;
    rst_n = 1'b1; start = 1'b0; len_x = '0; len_h = '0;
`ifdef CONV_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    m_cfg = 1'b0; m_rom = '0; m_x = '0;
    fill_mems();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_outs", {mac_clr, mac_en, out_valid, cfg_err}, 0);
    chk("reset_addr_idx", {rom_addr, x_addr, out_idx}, 0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // len_x=3, len_h=2
    launch(3, 2);
    chk("pin_3x2_len", q.size(), 16);
    chk("pin_3x2_n1_acc", {q[5].en, q[5].rom, q[5].xa, q[6].en, q[6].rom, q[6].xa},
        {1'b1, 6'd0, 6'd1, 1'b1, 6'd1, 6'd0});
    chk("pin_3x2_done", q[15].done, 1);
    release_start();
    wait_idle(100);
    chk("ov_3x2", ov_cnt, 4);
    chk("done_cycle_3x2", done_cyc - cyc0 + 1, 15);
    chk("cfg_3x2", cfg_err, 0);

    // oversize len_x, then a valid start clears cfg_err
    launch(51, 4);
    release_start();
    wait_idle(20);
    chk("cfg_51x4", cfg_err, 1);
    chk("ov_51x4", ov_cnt, 0);
    chk("done_cycle_51x4", done_cyc - cyc0 + 1, 1);
    launch(4, 3);
    release_start();
    chk("cfg_cleared", cfg_err, 0);
    wait_idle(200);

    // len_h = 0
    launch(5, 0);
    release_start();
    wait_idle(20);
    chk("done_cycle_h0", done_cyc - cyc0 + 1, 1);
    chk("ov_h0", ov_cnt, 0);

    // maximum lengths
    fill_mems();
    launch(50, 32);
    chk("pin_max_len", q.size(), 1764);
    chk("pin_max_last_acc", {q[1761].en, q[1761].rom, q[1761].xa}, {1'b1, 6'd31, 6'd49});
    chk("pin_max_done", q[1763].done, 1);
    release_start();
    wait_idle(3000);
    chk("ov_max", ov_cnt, 81);
    chk("done_cycle_max", done_cyc - cyc0 + 1, 1763);

    // start mid-run is ignored
    launch(6, 4);
    release_start();
    repeat (7) @(posedge clk);
    #1;
    len_x = 6'd2; len_h = 6'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(200);
    chk("ov_midstart", ov_cnt, 9);
    chk("done_midstart", done_cnt, 1);

    // reset during ACC of n=5
    launch(10, 8);
    e4 = -1; seen = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].ov && e4 < 0) begin
        if (seen == 4) e4 = i;
        seen++;
      end
    release_start();
    repeat (e4 + 1) @(posedge clk);
    #1;
    chk("pre_reset_acc", {mac_en, out_idx}, {1'b1, 7'd5});
    rst_n = 1'b0;
    #1;
    q.delete();
    m_cfg = 1'b0; m_rom = '0; m_x = '0;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {mac_clr, mac_en, out_valid, done, cfg_err}, 0);
    chk("abort_addr_idx", {rom_addr, x_addr, out_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);

    // randomized runs, including some rejected and empty configurations
    for (int r = 0; r < 25; r++) begin
      fill_mems();
      lx  = int'($urandom_range(1, MAX_X));
      lh  = int'($urandom_range(1, MAX_H));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) lx = int'($urandom_range(MAX_X + 1, 63));
      if (sel == 1) lh = int'($urandom_range(MAX_H + 1, 63));
      if (sel == 2) lx = 0;
      launch(lx, lh);
      release_start();
      repeat (int'($urandom_range(0, 3))) begin
        @(posedge clk);
        #1;
      end
      wait_idle(4000);
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
